// File: rtl/mod_mul_dual_if.sv
// Operand/result bundle between the NTT datapath and the dual-mode modular multiplier.
// The master drives operands and the enable; the slave (multiplier) returns the product.
interface mod_mul_dual_if;
  logic        mm_en;
  logic        mm_valid_in;
  logic        mm_mode;
  logic [23:0] mm_a;
  logic [23:0] mm_b;
  logic [23:0] mm_prod;
  logic        mm_valid_out;
  logic        mm_mode_out;

  modport master (
    output mm_en, mm_valid_in, mm_mode, mm_a, mm_b,
    input  mm_prod, mm_valid_out, mm_mode_out
  );

  modport slave (
    input  mm_en, mm_valid_in, mm_mode, mm_a, mm_b,
    output mm_prod, mm_valid_out, mm_mode_out
  );
endinterface

// File: rtl/mod_mul_dual.sv
// Four-stage Barrett modular multiplier: two 12-bit lanes mod KQ (mode 0)
// or one 24-bit lane mod DQ (mode 1), with a global stall enable.
module mod_mul_dual #(
  parameter int KQ = 3329,
  parameter int DQ = 8380417
) (
  input logic          clk,
  input logic          rst,
  mod_mul_dual_if.slave mm
);

  localparam int LAT = 4;

  localparam logic [23:0] KQ_V = 24'(KQ);
  localparam logic [47:0] DQ_V = 48'(DQ);
  // Barrett reciprocals: floor(2^24/KQ) for the lanes, floor(2^48/DQ) for the wide path
  localparam logic [23:0] M0   = 24'((64'd1 << 24) / 64'(KQ));
  localparam logic [47:0] M1   = 48'((64'd1 << 48) / 64'(DQ));

  logic [LAT-1:0] vld;
  logic [LAT-1:0] mode;
  logic [23:0]    a1, b1;
  logic [47:0]    x2, x3, qq3;
  logic [23:0]    prod4;

  logic [47:0]    x2_d, qq3_d;
  logic [23:0]    prod4_d;

  function automatic logic [23:0] lane_qq(input logic [23:0] x);
    logic [47:0] t;
    logic [23:0] quot;
    t    = 48'(x) * 48'(M0);
    quot = 24'(t >> 24);
    return quot * KQ_V;
  endfunction

  function automatic logic [47:0] wide_qq(input logic [47:0] x);
    logic [95:0] t;
    logic [47:0] quot;
    t    = 96'(x) * 96'(M1);
    quot = 48'(t >> 48);
    return quot * DQ_V;
  endfunction

  // The quotient estimate undershoots by at most 2, so two subtractions fully reduce
  function automatic logic [23:0] fix_up(input logic [24:0] r_in, input logic [24:0] q);
    logic [24:0] r;
    r = r_in;
    if (r >= q) r = r - q;
    if (r >= q) r = r - q;
    return r[23:0];
  endfunction

  always_comb begin
    x2_d = '0;
    if (mode[0])
      x2_d = 48'(a1) * 48'(b1);
    else
      x2_d = {24'(a1[23:12]) * 24'(b1[23:12]), 24'(a1[11:0]) * 24'(b1[11:0])};
  end

  always_comb begin
    qq3_d = '0;
    if (mode[1])
      qq3_d = wide_qq(x2);
    else
      qq3_d = {lane_qq(x2[47:24]), lane_qq(x2[23:0])};
  end

  always_comb begin
    prod4_d = '0;
    if (mode[2])
      prod4_d = fix_up(25'(x3 - qq3), 25'(DQ));
    else
      prod4_d = {12'(fix_up(25'(x3[47:24] - qq3[47:24]), 25'(KQ))),
                 12'(fix_up(25'(x3[23:0]  - qq3[23:0]),  25'(KQ)))};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld   <= '0;
      mode  <= '0;
      a1    <= '0;
      b1    <= '0;
      x2    <= '0;
      x3    <= '0;
      qq3   <= '0;
      prod4 <= '0;
    end else if (mm.mm_en) begin
      vld   <= {vld[LAT-2:0], mm.mm_valid_in};
      mode  <= {mode[LAT-2:0], mm.mm_mode};
      a1    <= mm.mm_a;
      b1    <= mm.mm_b;
      x2    <= x2_d;
      x3    <= x2;
      qq3   <= qq3_d;
      prod4 <= prod4_d;
    end
  end

  assign mm.mm_prod      = prod4;
  assign mm.mm_valid_out = vld[LAT-1];
  assign mm.mm_mode_out  = mode[LAT-1];

endmodule

// File: tb/tb_mod_mul_dual.sv
// Scoreboard bench for mod_mul_dual: the driver queues expected results,
// a negedge monitor pops and compares them as the pipeline emits.
module tb_mod_mul_dual;

  logic clk;
  logic rst;
  mod_mul_dual_if ifc();

  mod_mul_dual dut (
    .clk (clk),
    .rst (rst),
    .mm  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] prod;
    logic        mode;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   en_count = 0;
  logic en_q = 1'b0;

  function automatic logic [23:0] ref_mul(input logic m, input logic [23:0] a, input logic [23:0] b);
    if (m)
      return 24'((64'(a) * 64'(b)) % 64'd8380417);
    return {12'((64'(a[23:12]) * 64'(b[23:12])) % 64'd3329),
            12'((64'(a[11:0])  * 64'(b[11:0]))  % 64'd3329)};
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs; a tracked item that will really be captured is queued
  task automatic applyStimulus(input logic en, input logic vin, input logic m,
                               input logic [23:0] a, input logic [23:0] b,
                               input logic track, input logic [23:0] exp);
    ifc.mm_en       = en;
    ifc.mm_valid_in = vin;
    ifc.mm_mode     = m;
    ifc.mm_a        = a;
    ifc.mm_b        = b;
    if (track && en && vin)
      sb.push_back('{prod: exp, mode: m, due: en_count + 4});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom), 24'($urandom), 1'b0, 24'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle_cycle();
      n++;
    end
    checkOutput("drain_empty", 48'(sb.size()), 48'd0);
  endtask

  always @(posedge clk) begin
    en_q <= rst && ifc.mm_en;
    if (rst && ifc.mm_en)
      en_count <= en_count + 1;
  end

  // Outputs are only new after an enabled edge; held values during a stall are not re-popped
  always @(negedge clk) begin
    if (rst && en_q && ifc.mm_valid_out) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_output: got prod 0x%0h mode %0d, expected no output",
                 ifc.mm_prod, ifc.mm_mode_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("prod", 48'(ifc.mm_prod), 48'(e.prod));
        checkOutput("mode_tag", 48'(ifc.mm_mode_out), 48'(e.mode));
        checkOutput("latency", 48'(en_count), 48'(e.due));
      end
    end
  end

  initial begin
    logic        m;
    logic [23:0] a, b;

    rst             = 1'b0;
    ifc.mm_en       = 1'b1;
    ifc.mm_valid_in = 1'b0;
    ifc.mm_mode     = 1'b0;
    ifc.mm_a        = '0;
    ifc.mm_b        = '0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom), 24'($urandom), 24'($urandom), 1'b0, 24'd0);
      checkOutput("reset_prod", 48'(ifc.mm_prod), 48'd0);
      checkOutput("reset_valid", 48'(ifc.mm_valid_out), 48'd0);
      checkOutput("reset_mode", 48'(ifc.mm_mode_out), 48'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      checkOutput("idle_valid", 48'(ifc.mm_valid_out), 48'd0);
    end

    // Directed vectors, issued back to back
    applyStimulus(1, 1, 0, 24'hD00011, 24'hD00002, 1, 24'h001022);
    applyStimulus(1, 1, 1, 24'd8380416, 24'd8380416, 1, 24'd1);
    applyStimulus(1, 1, 1, 24'd4194304, 24'd2, 1, 24'd8191);
    applyStimulus(1, 1, 0, 24'hFFFFFF, 24'hFFFFFF, 1, 24'h354354);
    applyStimulus(1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 1, 24'd163817);
    applyStimulus(1, 1, 0, 24'h000000, 24'h123456, 1, 24'h000000);
    applyStimulus(1, 1, 0, 24'hD01005, 24'h002D01, 1, 24'h000000);
    applyStimulus(1, 1, 1, 24'd8380417, 24'd5, 1, 24'd0);
    applyStimulus(1, 1, 1, 24'd1000000, 24'd1000, 1, 24'd2730377);
    applyStimulus(1, 1, 0, 24'h3E87D0, 24'hBB8BB8, 1, 24'h23B476);
    drain();

    // Mixed-mode stream with out-of-range operands sprinkled in
    for (int i = 0; i < 64; i++) begin
      m = 1'(i % 2);
      a = 24'($urandom);
      b = 24'($urandom);
      if (i % 8 < 2) begin
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
      end else if (i % 8 == 2) begin
        a = m ? 24'd8380416 : 24'hD00D00;
      end else if (i % 8 == 3) begin
        a = m ? 24'd8380417 : 24'hD01D01;
      end
      applyStimulus(1'b1, 1'b1, m, a, b, 1'b1, ref_mul(m, a, b));
    end
    drain();

    // Stall mid-flight: output must freeze on the first item while valid_in toggles
    applyStimulus(1, 1, 0, 24'hD00011, 24'hD00002, 1, 24'h001022);
    applyStimulus(1, 1, 1, 24'd4194304, 24'd2, 1, 24'd8191);
    applyStimulus(1, 1, 1, 24'd8380416, 24'd8380416, 1, 24'd1);
    idle_cycle();
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, 1'(s % 2 == 0), 1'b1, 24'($urandom), 24'($urandom), 1'b1, 24'd0);
      checkOutput("stall_prod", 48'(ifc.mm_prod), 48'h001022);
      checkOutput("stall_valid", 48'(ifc.mm_valid_out), 48'd1);
      checkOutput("stall_mode", 48'(ifc.mm_mode_out), 48'd0);
    end
    drain();

    // Async reset pulse between edges while three untracked items are in flight
    applyStimulus(1, 1, 1, 24'd4194304, 24'd2, 1, 24'd8191);
    applyStimulus(1, 1, 0, 24'h3E87D0, 24'hBB8BB8, 0, 24'd0);
    applyStimulus(1, 1, 1, 24'd1000000, 24'd1000, 0, 24'd0);
    applyStimulus(1, 1, 0, 24'hD00011, 24'hD00002, 0, 24'd0);
    ifc.mm_valid_in = 1'b0;
    #5;
    rst = 1'b0;
    #1;
    checkOutput("async_valid", 48'(ifc.mm_valid_out), 48'd0);
    checkOutput("async_prod", 48'(ifc.mm_prod), 48'd0);
    checkOutput("async_mode", 48'(ifc.mm_mode_out), 48'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      idle_cycle();
      checkOutput("post_reset_valid", 48'(ifc.mm_valid_out), 48'd0);
    end
    checkOutput("final_queue_empty", 48'(sb.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
